// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter: command encodings,
// scheduler states and default widths.
package sdram_arb_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_NCH      = 2;
    localparam int DEF_ASIZE    = 23;
    localparam int DEF_LSIZE    = 9;
    localparam int DEF_LVLW     = 16;
    localparam int DEF_RD_DEPTH = 512;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational rotating priority picker: the first set request at or after
// START (wrapping) wins. With START tied to 0 it is a plain lowest-index
// fixed-priority picker.
module sdram_rr_pick #(
    parameter int N  = 4,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;

    // Rotate so START lands on bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> start);
        gnt_rot = req_rot & (~req_rot + N'(1));
        gnt_dbl = {gnt_rot, gnt_rot};
        grant   = N'((gnt_dbl << start) >> N);
        valid   = |req;
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Multi-channel SDRAM burst scheduler. Picks one eligible write/read channel,
// issues a single burst command, waits for the transfer to finish and then
// advances that channel's circular address pointer.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise writes beat
// reads and the lower channel index wins.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int ASIZE    = DEF_ASIZE,
    parameter int LSIZE    = DEF_LSIZE,
    parameter int LVLW     = DEF_LVLW,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NCH*LVLW-1:0]  WR_LEVEL,
    input  logic [NCH*LVLW-1:0]  RD_LEVEL,
    input  logic [NCH*ASIZE-1:0] WR_BASE,
    input  logic [NCH*ASIZE-1:0] WR_MAX,
    input  logic [NCH*ASIZE-1:0] RD_BASE,
    input  logic [NCH*ASIZE-1:0] RD_MAX,
    input  logic [NCH*LSIZE-1:0] WR_LEN,
    input  logic [NCH*LSIZE-1:0] RD_LEN,
    input  logic [NCH-1:0]       WR_LOAD,
    input  logic [NCH-1:0]       RD_LOAD,
    output logic [1:0]           CMD,
    output logic [ASIZE-1:0]     ADDR,
    output logic [LSIZE-1:0]     LENGTH,
    input  logic                 CMD_ACK,
    input  logic                 XFER_DONE,
    output logic [NCH-1:0]       WR_SEL,
    output logic [NCH-1:0]       RD_SEL,
    output logic                 BUSY
);

    localparam int NREQ = 2 * NCH;
    localparam int SW   = $clog2(NREQ);

    arb_state_t       state_reg, state_next;
    logic             grant_go;
    logic [1:0]       cmd_reg;
    logic [ASIZE-1:0] addr_reg;
    logic [LSIZE-1:0] length_reg;
    logic [NCH-1:0]   wr_sel_reg, rd_sel_reg;
    logic             busy_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic             sup_reg;
    logic [ASIZE-1:0] wr_ptr_reg [NCH];
    logic [ASIZE-1:0] rd_ptr_reg [NCH];

    logic [NREQ-1:0]  req, loads, pick_grant;
    logic             pick_valid;
    logic [SW-1:0]    pick_start;
    logic [ASIZE-1:0] pick_addr;
    logic [LSIZE-1:0] pick_len;

    // Circular advance, evaluated one bit wider so max-len cannot wrap.
    function automatic logic [ASIZE-1:0] ptr_advance(
        input logic [ASIZE-1:0] ptr,
        input logic [ASIZE-1:0] base,
        input logic [ASIZE-1:0] max,
        input logic [LSIZE-1:0] len
    );
        logic [ASIZE:0] ptr_x, max_x, len_x;
        ptr_x = {1'b0, ptr};
        max_x = {1'b0, max};
        len_x = (ASIZE+1)'(len);
        if (max_x < len_x)
            return base;
        else if (ptr_x < max_x - len_x)
            return ptr + ASIZE'(len);
        else
            return base;
    endfunction

    // Per-channel eligibility; read headroom is summed one bit wider.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
        logic [LVLW:0] wr_lvl_x, wr_len_x, rd_sum_x;
        assign wr_lvl_x = (LVLW+1)'(WR_LEVEL[gi*LVLW +: LVLW]);
        assign wr_len_x = (LVLW+1)'(WR_LEN[gi*LSIZE +: LSIZE]);
        assign rd_sum_x = (LVLW+1)'(RD_LEVEL[gi*LVLW +: LVLW])
                        + (LVLW+1)'(RD_LEN[gi*LSIZE +: LSIZE]);
        assign req[gi]     = (WR_LEN[gi*LSIZE +: LSIZE] != '0) && !WR_LOAD[gi]
                           && (wr_lvl_x >= wr_len_x);
        assign req[NCH+gi] = (RD_LEN[gi*LSIZE +: LSIZE] != '0) && !RD_LOAD[gi]
                           && (rd_sum_x <= (LVLW+1)'(RD_DEPTH));
    end

    assign loads = {RD_LOAD, WR_LOAD};

`ifdef SDRAM_ARB_RR_EN
    logic [SW-1:0] rr_reg;
    logic [SW-1:0] gnt_idx;

    // Index of the burst currently in flight, for the round-robin advance.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++)
            if (gnt_reg[k]) gnt_idx = SW'(k);
    end

    // Round-robin pointer moves past the served request when DONE retires.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            rr_reg <= '0;
        else if (state_reg == DONE)
            rr_reg <= (gnt_idx == SW'(NREQ-1)) ? '0 : gnt_idx + SW'(1);
    end

    assign pick_start = rr_reg;
`else
    assign pick_start = '0;
`endif

    sdram_rr_pick #(.N(NREQ), .SW(SW)) u_pick (
        .req   (req),
        .start (pick_start),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Address and length of the candidate grant.
    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (pick_grant[k]) begin
                pick_addr = wr_ptr_reg[k];
                pick_len  = WR_LEN[k*LSIZE +: LSIZE];
            end
            if (pick_grant[NCH+k]) begin
                pick_addr = rd_ptr_reg[k];
                pick_len  = RD_LEN[k*LSIZE +: LSIZE];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; a pending LOAD holds off any new grant.
    always_comb begin
        state_next = state_reg;
        grant_go   = 1'b0;
        case (state_reg)
            IDLE:    if (pick_valid && !(|loads)) begin
                         state_next = ISSUE;
                         grant_go   = 1'b1;
                     end
            ISSUE:   if (CMD_ACK)   state_next = XFER;
            XFER:    if (XFER_DONE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command outputs, grant latch and LOAD-during-burst suppression flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_reg    <= CMD_IDLE;
            addr_reg   <= '0;
            length_reg <= '0;
            wr_sel_reg <= '0;
            rd_sel_reg <= '0;
            busy_reg   <= 1'b0;
            gnt_reg    <= '0;
            sup_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (grant_go) begin
                    cmd_reg    <= (|pick_grant[NCH-1:0]) ? CMD_WRITE : CMD_READ;
                    addr_reg   <= pick_addr;
                    length_reg <= pick_len;
                    wr_sel_reg <= pick_grant[NCH-1:0];
                    rd_sel_reg <= pick_grant[NREQ-1:NCH];
                    busy_reg   <= 1'b1;
                    gnt_reg    <= pick_grant;
                    sup_reg    <= 1'b0;
                end
                ISSUE: if (CMD_ACK) cmd_reg <= CMD_IDLE;
                DONE: begin
                    wr_sel_reg <= '0;
                    rd_sel_reg <= '0;
                    busy_reg   <= 1'b0;
                end
                default: ;
            endcase
            if (state_reg != IDLE && |(loads & gnt_reg))
                sup_reg <= 1'b1;
        end
    end

    // Channel pointers: LOAD reloads base and beats the DONE advance.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NCH; k++) begin
                wr_ptr_reg[k] <= '0;
                rd_ptr_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (WR_LOAD[k])
                    wr_ptr_reg[k] <= WR_BASE[k*ASIZE +: ASIZE];
                else if (state_reg == DONE && gnt_reg[k] && !sup_reg)
                    wr_ptr_reg[k] <= ptr_advance(wr_ptr_reg[k], WR_BASE[k*ASIZE +: ASIZE],
                                                 WR_MAX[k*ASIZE +: ASIZE], WR_LEN[k*LSIZE +: LSIZE]);
                if (RD_LOAD[k])
                    rd_ptr_reg[k] <= RD_BASE[k*ASIZE +: ASIZE];
                else if (state_reg == DONE && gnt_reg[NCH+k] && !sup_reg)
                    rd_ptr_reg[k] <= ptr_advance(rd_ptr_reg[k], RD_BASE[k*ASIZE +: ASIZE],
                                                 RD_MAX[k*ASIZE +: ASIZE], RD_LEN[k*LSIZE +: LSIZE]);
            end
        end
    end

    assign CMD    = cmd_reg;
    assign ADDR   = addr_reg;
    assign LENGTH = length_reg;
    assign WR_SEL = wr_sel_reg;
    assign RD_SEL = rd_sel_reg;
    assign BUSY   = busy_reg;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter (NCH=2). Honours SDRAM_ARB_RR_EN
// so the reference arbitration matches the build.
module tb_sdram_burst_arbiter;

    localparam int NCH = 2, ASIZE = 23, LSIZE = 9, LVLW = 16, RD_DEPTH = 512;

    logic                 CLK = 1'b0;
    logic                 RESET_N;
    logic [NCH*LVLW-1:0]  WR_LEVEL, RD_LEVEL;
    logic [NCH*ASIZE-1:0] WR_BASE, WR_MAX, RD_BASE, RD_MAX;
    logic [NCH*LSIZE-1:0] WR_LEN, RD_LEN;
    logic [NCH-1:0]       WR_LOAD, RD_LOAD;
    logic [1:0]           CMD;
    logic [ASIZE-1:0]     ADDR;
    logic [LSIZE-1:0]     LENGTH;
    logic                 CMD_ACK, XFER_DONE;
    logic [NCH-1:0]       WR_SEL, RD_SEL;
    logic                 BUSY;

    sdram_burst_arbiter #(.NCH(NCH), .ASIZE(ASIZE), .LSIZE(LSIZE), .LVLW(LVLW), .RD_DEPTH(RD_DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .WR_LEVEL(WR_LEVEL), .RD_LEVEL(RD_LEVEL),
        .WR_BASE(WR_BASE), .WR_MAX(WR_MAX), .RD_BASE(RD_BASE), .RD_MAX(RD_MAX),
        .WR_LEN(WR_LEN), .RD_LEN(RD_LEN), .WR_LOAD(WR_LOAD), .RD_LOAD(RD_LOAD),
        .CMD(CMD), .ADDR(ADDR), .LENGTH(LENGTH), .CMD_ACK(CMD_ACK), .XFER_DONE(XFER_DONE),
        .WR_SEL(WR_SEL), .RD_SEL(RD_SEL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference state, indexed by request id: 0,1 = writes, 2,3 = reads.
    int base_m [4];
    int max_m  [4];
    int len_m  [4];
    int lvl_m  [4];
    int ptr_m  [4];
    int rr_m;
    int n_checks = 0;
    int n_fail   = 0;
    int n_burst  = 0;

    typedef struct {
        int         wl0, wl1, rl0, rl1;
        logic [3:0] exp_elig;   // {R1,R0,W1,W0}
        int         nb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cfg();
        for (int i = 0; i < NCH; i++) begin
            WR_BASE[i*ASIZE +: ASIZE]  = ASIZE'(base_m[i]);
            WR_MAX[i*ASIZE +: ASIZE]   = ASIZE'(max_m[i]);
            WR_LEN[i*LSIZE +: LSIZE]   = LSIZE'(len_m[i]);
            WR_LEVEL[i*LVLW +: LVLW]   = LVLW'(lvl_m[i]);
            RD_BASE[i*ASIZE +: ASIZE]  = ASIZE'(base_m[i+NCH]);
            RD_MAX[i*ASIZE +: ASIZE]   = ASIZE'(max_m[i+NCH]);
            RD_LEN[i*LSIZE +: LSIZE]   = LSIZE'(len_m[i+NCH]);
            RD_LEVEL[i*LVLW +: LVLW]   = LVLW'(lvl_m[i+NCH]);
        end
    endtask

    // Eligibility straight from the level/length rules.
    function automatic logic [3:0] m_elig();
        logic [3:0] e = '0;
        for (int r = 0; r < 4; r++) begin
            if (len_m[r] == 0)  e[r] = 1'b0;
            else if (r < NCH)   e[r] = (lvl_m[r] >= len_m[r]);
            else                e[r] = (lvl_m[r] + len_m[r] <= RD_DEPTH);
        end
        return e;
    endfunction

    function automatic int m_pick(input logic [3:0] el);
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_RR_EN
            int idx = (rr_m + k) % 4;
`else
            int idx = k;
`endif
            if (el[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int m_adv(input int r);
        if (max_m[r] < len_m[r])                return base_m[r];
        if (ptr_m[r] < max_m[r] - len_m[r])     return ptr_m[r] + len_m[r];
        return base_m[r];
    endfunction

    task automatic pulse_loads(input logic [3:0] m);
        {RD_LOAD, WR_LOAD} = m;
        @(posedge CLK); #1;
        {RD_LOAD, WR_LOAD} = '0;
        for (int r = 0; r < 4; r++) if (m[r]) ptr_m[r] = base_m[r];
    endtask

    // One full burst for request g; lm is a LOAD mask pulsed in XFER.
    task automatic run_burst(input int g, input logic [3:0] lm, input int ack_dly,
                             input int done_dly, output int waited);
        logic [1:0] exp_cmd = (g < NCH) ? 2'b10 : 2'b01;
        logic [3:0] exp_sel = 4'(1) << g;
        waited = 0;
        do begin @(posedge CLK); #1; waited++; end while (CMD == 2'b00 && waited < 20);
        chk("cmd_issue", CMD, exp_cmd);
        if (CMD == 2'b00) return;
        chk("addr", ADDR, ptr_m[g]);
        chk("length", LENGTH, len_m[g]);
        chk("sel_issue", {RD_SEL, WR_SEL}, exp_sel);
        chk("busy_issue", BUSY, 1);
        $display("burst %0d: req=%0d cmd=%0d addr=0x%0h len=%0d", n_burst, g, CMD, ADDR, LENGTH);
        n_burst++;
        for (int i = 0; i < ack_dly; i++) begin
            XFER_DONE = 1'b1;                 // stray pulse, must be ignored
            @(posedge CLK); #1;
            XFER_DONE = 1'b0;
            chk("cmd_hold", CMD, exp_cmd);
        end
        CMD_ACK = 1'b1;
        @(posedge CLK); #1;
        CMD_ACK = 1'b0;
        chk("cmd_after_ack", CMD, 0);
        chk("sel_xfer", {RD_SEL, WR_SEL}, exp_sel);
        {RD_LOAD, WR_LOAD} = lm;
        CMD_ACK = 1'b1;                       // stray ack, must be ignored
        @(posedge CLK); #1;
        {RD_LOAD, WR_LOAD} = '0;
        CMD_ACK = 1'b0;
        chk("busy_xfer", BUSY, 1);
        chk("cmd_xfer", CMD, 0);
        repeat (done_dly) begin @(posedge CLK); #1; end
        XFER_DONE = 1'b1;
        @(posedge CLK); #1;
        XFER_DONE = 1'b0;
        chk("busy_done", BUSY, 1);
        @(posedge CLK); #1;
        chk("busy_idle", BUSY, 0);
        chk("sel_idle", {RD_SEL, WR_SEL}, 0);
    endtask

    task automatic do_burst(input logic [3:0] el, input logic [3:0] lm, input int ack_dly,
                            input int done_dly, output int waited);
        int g = m_pick(el);
        waited = 0;
        if (g < 0) begin
            logic seen = 1'b0;
            repeat (6) begin
                @(posedge CLK); #1;
                if (CMD != 2'b00 || BUSY) seen = 1'b1;
            end
            chk("no_grant", seen, 0);
            return;
        end
        run_burst(g, lm, ack_dly, done_dly, waited);
        for (int r = 0; r < 4; r++) if (lm[r]) ptr_m[r] = base_m[r];
        if (!lm[g]) ptr_m[g] = m_adv(g);
        rr_m = (g + 1) % 4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] lm;

        for (int r = 0; r < 4; r++) begin
            base_m[r] = 0; max_m[r] = 0; len_m[r] = 0; lvl_m[r] = 0; ptr_m[r] = 0;
        end
        rr_m = 0;
        RESET_N = 1'b0; CMD_ACK = 1'b0; XFER_DONE = 1'b0; WR_LOAD = '0; RD_LOAD = '0;
        push_cfg();
        #22;
        chk("rst_cmd", CMD, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_length", LENGTH, 0);
        chk("rst_sel", {RD_SEL, WR_SEL}, 0);
        chk("rst_busy", BUSY, 0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // First write burst, pointer advance and wrap to base.
        base_m[0] = 'h100; max_m[0] = 'h1000; len_m[0] = 256; lvl_m[0] = 256;
        push_cfg();
        pulse_loads(4'b0001);
        do_burst(m_elig(), 4'b0000, 1, 1, w);
        max_m[0] = 'h300; push_cfg();
        do_burst(m_elig(), 4'b0000, 0, 0, w);
        chk("gap_back_to_back", w, 1);
        do_burst(m_elig(), 4'b0000, 2, 0, w);

        // LOAD of R1 during its XFER: next burst restarts at base, no advance.
        lvl_m[0] = 0;
        base_m[1] = 'h2000; max_m[1] = 'h2030; len_m[1] = 16;  lvl_m[1] = 0;
        base_m[2] = 'h4000; max_m[2] = 'h4300; len_m[2] = 256; lvl_m[2] = 500;
        base_m[3] = 'h6000; max_m[3] = 'h7000; len_m[3] = 100; lvl_m[3] = 0;
        push_cfg();
        pulse_loads(4'b1111);
        do_burst(m_elig(), 4'b0000, 0, 1, w);
        do_burst(m_elig(), 4'b1000, 1, 0, w);
        do_burst(m_elig(), 4'b0000, 0, 0, w);

        // Table: levels vs hand-derived eligibility; R1 now has max < len.
        max_m[3] = 'h50;
        vecs[0] = '{wl0:0,    wl1:0,    rl0:257, rl1:413, exp_elig:4'b0000, nb:1};
        vecs[1] = '{wl0:256,  wl1:0,    rl0:257, rl1:413, exp_elig:4'b0001, nb:2};
        vecs[2] = '{wl0:255,  wl1:16,   rl0:257, rl1:412, exp_elig:4'b1010, nb:3};
        vecs[3] = '{wl0:0,    wl1:15,   rl0:256, rl1:500, exp_elig:4'b0100, nb:2};
        vecs[4] = '{wl0:1000, wl1:1000, rl0:0,   rl1:0,   exp_elig:4'b1111, nb:5};
        vecs[5] = '{wl0:0,    wl1:0,    rl0:256, rl1:0,   exp_elig:4'b1100, nb:3};
        for (int v = 0; v < 6; v++) begin
            lvl_m[0] = vecs[v].wl0; lvl_m[1] = vecs[v].wl1;
            lvl_m[2] = vecs[v].rl0; lvl_m[3] = vecs[v].rl1;
            push_cfg();
            for (int b = 0; b < vecs[v].nb; b++)
                do_burst(vecs[v].exp_elig, 4'b0000, b % 2, (b + 1) % 3, w);
        end

        // Randomized levels, handshake delays and occasional LOADs.
        for (int it = 0; it < 40; it++) begin
            lvl_m[0] = $urandom_range(200, 300);
            lvl_m[1] = $urandom_range(0, 30);
            lvl_m[2] = $urandom_range(200, 300);
            lvl_m[3] = $urandom_range(380, 450);
            push_cfg();
            lm = ($urandom_range(0, 3) == 0) ? 4'(1) << $urandom_range(0, 3) : 4'b0000;
            do_burst(m_elig(), lm, $urandom_range(0, 2), $urandom_range(0, 2), w);
        end

        // Asynchronous reset in the middle of a burst.
        lvl_m[0] = 256; lvl_m[1] = 0; lvl_m[2] = 500; lvl_m[3] = 600;
        push_cfg();
        w = 0;
        do begin @(posedge CLK); #1; w++; end while (CMD == 2'b00 && w < 20);
        chk("rst_burst_cmd", CMD, 2'b10);
        CMD_ACK = 1'b1;
        @(posedge CLK); #1;
        CMD_ACK = 1'b0;
        @(posedge CLK); #3;
        RESET_N = 1'b0;
        #1;
        chk("async_cmd", CMD, 0);
        chk("async_sel", {RD_SEL, WR_SEL}, 0);
        chk("async_busy", BUSY, 0);
        chk("async_addr", ADDR, 0);
        lvl_m[0] = 0; push_cfg();
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        for (int r = 0; r < 4; r++) ptr_m[r] = 0;
        rr_m = 0;
        do_burst(m_elig(), 4'b0000, 0, 0, w);
        lvl_m[0] = 256; push_cfg();
        do_burst(m_elig(), 4'b0000, 0, 0, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
